// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and helpers for the push-button conditioner
//
// Purpose : FSM state encoding for the per-channel auto-repeat machine and
//           constant functions that turn millisecond settings into clock
//           cycle counts.
// Ports   : none (package).

package btn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HELD   = 2'd3
   } btn_state_t;

   // Milliseconds to clock cycles. A zero result would make the "count - 1"
   // compare values negative, so the result never drops below one cycle.
   function automatic int ms_to_cyc(input int clk_hz, input int ms);
      int cyc;
      cyc = clk_hz / 1000 * ms;
      return (cyc < 1) ? 1 : cyc;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one key: synchroniser, debouncer and auto-repeat FSM
//
// Purpose : Conditions a single raw key pin into a clean debounced level,
//           a one-cycle press/repeat strobe and a long-hold flag.
// Ports   :
//   clkin     in   system clock
//   rst       in   asynchronous active-high reset
//   key_raw   in   raw key pin, asynchronous to clkin
//   key_level out  debounced level, 1 = pressed
//   key_pulse out  one-cycle strobe on press and on each auto-repeat
//   key_long  out  1 while the key has been held past the hold delay

module btn_channel
   import btn_pkg::*;
#(
   parameter int DB_CYC     = 1,
   parameter int HOLD_CYC   = 1,
   parameter int RPT_CYC    = 1,
   parameter bit RPT_EN     = 1'b0,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clkin,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_pulse,
   output logic key_long
);

   localparam int            MAX_CYC   = max3(DB_CYC, HOLD_CYC, RPT_CYC);
   localparam int            CW        = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic          pressed_raw;
   logic          pin_q;
   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [CW-1:0] db_cnt_q;

   logic          differ;
   logic          flip;
   logic          rise;
   logic          fall;

   btn_state_t    state_q;
   btn_state_t    state_d;
   logic [CW-1:0] timer_q;
   logic [CW-1:0] timer_d;
   logic          pulse_q;
   logic          pulse_d;
   logic          long_q;
   logic          long_d;

   // ------------------------------------------------------------------
   // Input path: polarity is folded into the pin capture flop so that
   // everything downstream sees 1 = pressed. Two synchroniser flops
   // follow; all three reset to "released".
   // ------------------------------------------------------------------
   assign pressed_raw = ACTIVE_LOW ? ~key_raw : key_raw;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         pin_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         pin_q   <= pressed_raw;
         sync1_q <= pin_q;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Debounce: the synchronised input must disagree with the stable state
   // on DB_CYC consecutive edges before the stable state flips. Any cycle
   // of agreement restarts the count, so short glitches never get through.
   // ------------------------------------------------------------------
   assign differ = sync2_q ^ stable_q;
   assign flip   = differ && (db_cnt_q == DB_LAST);
   assign rise   = flip && !stable_q;
   assign fall   = flip &&  stable_q;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         stable_q <= 1'b0;
         db_cnt_q <= '0;
      end else if (flip) begin
         stable_q <= ~stable_q;
         db_cnt_q <= '0;
      end else if (differ) begin
         db_cnt_q <= db_cnt_q + CNT_ONE;
      end else begin
         db_cnt_q <= '0;
      end
   end

   // ------------------------------------------------------------------
   // Auto-repeat FSM. The FSM reacts to the flip condition itself rather
   // than to stable_q, so the press strobe is registered on the same edge
   // as the level and both outputs rise together.
   // ------------------------------------------------------------------
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         pulse_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
         long_q  <= long_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rise) begin
               pulse_d = 1'b1;
               state_d = DELAY;
               timer_d = '0;
            end
         end

         // Release is tested first so that a fall landing on the expiry
         // cycle wins: no repeat strobe, straight back to IDLE.
         DELAY: begin
            if (fall) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == HOLD_LAST) begin
               timer_d = '0;
               if (RPT_EN) begin
                  pulse_d = 1'b1;
                  state_d = REPEAT;
               end else begin
                  state_d = HELD;
               end
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end

         REPEAT: begin
            if (fall) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == RPT_LAST) begin
               pulse_d = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_ONE;
            end
         end

         // Timer is frozen here; nothing is waiting on it.
         HELD: begin
            if (fall) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      // Registered long flag tracks the state being entered, so it rises
      // together with the first repeat strobe or on HELD entry.
      long_d = (state_d == REPEAT) || (state_d == HELD);
   end

   assign key_level = stable_q;
   assign key_pulse = pulse_q;
   assign key_long  = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four-channel push-button front end
//
// Purpose : Four independent key channels, each synchronised, debounced and
//           turned into press/auto-repeat strobes for the countdown timer.
// Ports   :
//   clkin          in   system clock (single clock domain)
//   rst            in   asynchronous active-high reset
//   key_raw[3:0]   in   raw key pins, asynchronous to clkin
//   key_level[3:0] out  debounced levels, 1 = pressed
//   key_pulse[3:0] out  one-cycle strobes on press and auto-repeat
//   key_long[3:0]  out  1 while the key is held past the hold delay

module btn_conditioner
   import btn_pkg::*;
#(
   parameter int         CLK_HZ      = 50000000,
   parameter int         DEBOUNCE_MS = 20,
   parameter int         HOLD_MS     = 500,
   parameter int         REPEAT_MS   = 100,
   parameter logic [3:0] RPT_MASK    = 4'b0100,
   parameter bit         ACTIVE_LOW  = 1'b1
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic [3:0] key_raw,
   output logic [3:0] key_level,
   output logic [3:0] key_pulse,
   output logic [3:0] key_long
);

   localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int HOLD_CYC = ms_to_cyc(CLK_HZ, HOLD_MS);
   localparam int RPT_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

   for (genvar i = 0; i < 4; i++) begin : g_ch
      btn_channel #(
         .DB_CYC     (DB_CYC),
         .HOLD_CYC   (HOLD_CYC),
         .RPT_CYC    (RPT_CYC),
         .RPT_EN     (RPT_MASK[i]),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clkin     (clkin),
         .rst       (rst),
         .key_raw   (key_raw[i]),
         .key_level (key_level[i]),
         .key_pulse (key_pulse[i]),
         .key_long  (key_long[i])
      );
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Four-channel push-button front end for the countdown-timer board. Each channel synchronises a raw, bouncing key input, debounces it, and produces a one-cycle press pulse. Channels that are enabled for it also emit auto-repeat pulses while the key is held. The outputs feed the timer's pause, mode, increment and speed controls directly, so the `but2` increment can be held to scroll digits.

## Interface
Parameters:
- `CLK_HZ`, 50000000: clock frequency in Hz.
- `DEBOUNCE_MS`, 20: input must be stable this long before it is accepted.
- `HOLD_MS`, 500: delay from the initial press pulse to the first repeat pulse.
- `REPEAT_MS`, 100: period between later repeat pulses.
- `RPT_MASK`, 4'b0100: per-channel auto-repeat enable; default enables channel 2 only.
- `ACTIVE_LOW`, 1: 1 means raw keys read 0 when pressed.

Ports:
- `clkin` input 1: system clock. The block has one clock only.
- `rst` input 1: asynchronous, active-high reset.
- `key_raw` input 4: raw key pins. Asynchronous to `clkin`.
- `key_level` output 4: debounced level, 1 = pressed.
- `key_pulse` output 4: one-cycle strobe on the press edge and on each auto-repeat.
- `key_long` output 4: 1 while a key has been held past `HOLD_MS`.

## Operation
Per-channel derived constants (cycle counts):
- DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
- HOLD_CYC = CLK_HZ/1000*HOLD_MS
- RPT_CYC = CLK_HZ/1000*REPEAT_MS

Each is at least 1. Counter widths are $clog2 of the largest constant plus 1. Counters never wrap.

Input path:
- Polarity: raw input is inverted when `ACTIVE_LOW`=1, so that internally 1 means pressed.
- Synchroniser: two-flop, reset to 0 (released).

Debounce:
- Compare the synchroniser output against the stable state. While they differ, the counter increments.
- When the count reaches DB_CYC-1 while still differing, the stable state flips and the counter clears.
- Any cycle where they agree clears the counter. A glitch shorter than DB_CYC cycles is never accepted.
- `key_level` is the stable state.

Auto-repeat FSM (per channel), states IDLE, DELAY, REPEAT, HELD:
- IDLE: on stable rise, pulse and go to DELAY with the timer cleared.
- DELAY: on stable fall, go to IDLE with no pulse. On timer = HOLD_CYC-1, set long.
  - If the channel's `RPT_MASK` bit is 1: pulse, go to REPEAT, clear the timer.
  - If the bit is 0: go to HELD with no pulse.
- REPEAT: on timer = RPT_CYC-1, pulse and clear the timer. On stable fall, go to IDLE.
- HELD: on stable fall, go to IDLE.
- Release takes priority over timer expiry in the same cycle: no pulse, go to IDLE.
- `key_long` is 1 in REPEAT and HELD, and 0 otherwise.

Other rules:
- Channels are fully independent. Simultaneous presses give simultaneous pulses.
- Reset mid-operation: all channels return to IDLE and released. No pulse is generated on reset release, even if a key is held. A key held through reset is accepted after DB_CYC cycles and then pulses as a fresh press.

## Timing
- Reset values: `key_level`=0, `key_pulse`=0, `key_long`=0. Synchronisers, counters and FSM state are all cleared.
- All outputs are registered.
- Press latency: the first sampling edge of a clean raw press is edge 0. The synchroniser output goes to 1 after edge 2. The debounce counter reaches DB_CYC-1 at edge DB_CYC+1, so `key_level` and `key_pulse` rise together after edge DB_CYC+2.
- Release latency is the same, DB_CYC+2, for `key_level`.
- `key_pulse` is high for exactly one cycle per event and is never high on two consecutive cycles when RPT_CYC ≥ 2.
- First repeat pulse: HOLD_CYC cycles after the press pulse. Later repeats: every RPT_CYC cycles.
- `key_long` rises in the same cycle as the first repeat pulse, or on the HELD entry.

## Structure
- Package `btn_pkg`:
  - FSM state enum: IDLE, DELAY, REPEAT, HELD.
  - Function ms_to_cyc(clk_hz, ms), clamped to ≥ 1.
- Sub-module `btn_channel`: one synchroniser, debounce stage and FSM. Parameters: the three cycle counts, the repeat-enable bit, and polarity.
- `btn_conditioner` instantiates four `btn_channel`s with a generate loop.

## Test plan
All tests use CLK_HZ=1000, DEBOUNCE_MS=4, HOLD_MS=10, REPEAT_MS=3 (1 cycle = 1 ms) and ACTIVE_LOW=1.

1. Clean press: `key_raw`[0] goes 1→0 and is held 20 cycles, then released. Expect `key_level`[0]=1 exactly 6 cycles after the first sampling edge, exactly 1 `key_pulse`[0], `key_long`[0]=1 from 10 cycles after the pulse, and `key_level`[0]=0 6 cycles after release.
2. Bounce: on channel 1, toggle `key_raw` every 2 cycles for 12 cycles, then hold it low. Expect no pulse during the toggling and exactly one pulse 6 cycles after the final edge.
3. Auto-repeat: hold channel 2 for 25 cycles after its press pulse. Expect pulses at +0, +10, +13, +16, +19, +22, and then none after release.
4. Release on expiry: release channel 2 so that its stable fall lands on the cycle where the DELAY timer hits 9. Expect no repeat pulse, return to IDLE, and `key_long`=0.
5. Simultaneous presses: press channels 0 and 3 on the same cycle. Expect both `key_pulse` bits high in the same cycle, and channel 3 goes to HELD with no repeats.
6. Reset mid-hold: assert `rst` for 2 cycles asynchronously while channel 2 is in REPEAT, with the key held. Expect all outputs to go to 0 immediately, then a new press pulse 6 cycles after `rst` falls.
